// File: rtl/mem_ops_pkg.sv
// Shared definitions for the memory-stage access controller.
//   - op codes driven by the pipeline on Op
//   - default memory geometry (word address / data widths)
//   - controller state encoding and stack-pointer update commands
package mem_ops_pkg;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [2:0] {
        OpNop  = 3'd0,
        OpLdd  = 3'd1,
        OpStd  = 3'd2,
        OpPush = 3'd3,
        OpPop  = 3'd4,
        OpCall = 3'd5,
        OpRet  = 3'd6,
        OpRsvd = 3'd7
    } op_e;

    typedef enum logic {
        StIdle,
        StSecond
    } state_e;

    typedef enum logic [2:0] {
        SpHold,
        SpDec1,
        SpInc1,
        SpDec2,
        SpInc2
    } sp_upd_e;

endpackage

// File: rtl/stack_pointer.sv
// Stack pointer register for mem_access_ctrl.
// Holds the current top-of-stack word address and applies the -1/+1/-2/+2
// updates requested by the controller. Arithmetic wraps modulo 2^ADDR_W.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset, loads SP_RESET
//   upd_i  : update command for this cycle
//   sp_o   : current stack pointer
module stack_pointer #(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned SP_RESET = 2047
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  mem_ops_pkg::sp_upd_e    upd_i,
    output logic [ADDR_W-1:0]       sp_o
);
    import mem_ops_pkg::*;

    logic [ADDR_W-1:0] sp_d, sp_q;

    always_comb begin
        sp_d = sp_q;
        unique case (upd_i)
            SpHold:  sp_d = sp_q;
            SpDec1:  sp_d = sp_q - ADDR_W'(1);
            SpInc1:  sp_d = sp_q + ADDR_W'(1);
            SpDec2:  sp_d = sp_q - ADDR_W'(2);
            SpInc2:  sp_d = sp_q + ADDR_W'(2);
            default: sp_d = sp_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_q <= ADDR_W'(SP_RESET);
        end else begin
            sp_q <= sp_d;
        end
    end

    assign sp_o = sp_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage initiator for the single-port data memory.
// Turns pipeline memory ops into one- or two-word memory accesses, owns the
// stack pointer, and holds the pipeline for the 32-bit PC push (CALL) and
// pop (RET). Memory controls are combinational from state and request; the
// memory commits writes on the falling edge inside the access cycle.
//   Clk, Rst            : clock, asynchronous active-low reset
//   Req, Op             : request valid and op code (mem_ops_pkg::op_e)
//   EffAddr, WrData     : LDD/STD address, STD/PUSH data
//   PcIn / PcOut        : CALL return PC in, RET target PC out
//   Ready, Stall, Done  : idle/accepting, pipeline hold, completion pulse
//   RdData, Sp          : LDD/POP result, current stack pointer
//   MemeWrite, MemeRead, MemAddr, MemDataIn, MemDataOut : memory port
module mem_access_ctrl #(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned SP_RESET = 2047
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Req,
    input  logic [2:0]            Op,
    input  logic [ADDR_W-1:0]     EffAddr,
    input  logic [DATA_W-1:0]     WrData,
    input  logic [2*DATA_W-1:0]   PcIn,
    output logic                  Ready,
    output logic                  Stall,
    output logic                  Done,
    output logic [DATA_W-1:0]     RdData,
    output logic [2*DATA_W-1:0]   PcOut,
    output logic [ADDR_W-1:0]     Sp,
    output logic                  MemeWrite,
    output logic                  MemeRead,
    output logic [ADDR_W-1:0]     MemAddr,
    output logic [DATA_W-1:0]     MemDataIn,
    input  logic [DATA_W-1:0]     MemDataOut
);
    import mem_ops_pkg::*;

    state_e                state_d, state_q;
    op_e                   op_d, op_q;        // which two-word op is in flight
    logic                  done_d, done_q;
    logic [DATA_W-1:0]     rd_data_d, rd_data_q;
    logic [2*DATA_W-1:0]   pc_out_d, pc_out_q;
    logic [DATA_W-1:0]     pc_lo_d, pc_lo_q;  // low PC word carried into SECOND
    sp_upd_e               sp_upd;
    logic                  mem_we, mem_re, stall;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    op_e                   req_op;

    assign req_op = op_e'(Op);

    stack_pointer #(
        .ADDR_W   (ADDR_W),
        .SP_RESET (SP_RESET)
    ) u_stack_pointer (
        .clk_i  (Clk),
        .rst_ni (Rst),
        .upd_i  (sp_upd),
        .sp_o   (Sp)
    );

    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        stall     = 1'b0;
        sp_upd    = SpHold;
        state_d   = state_q;
        op_d      = op_q;
        done_d    = 1'b0;
        rd_data_d = rd_data_q;
        pc_out_d  = pc_out_q;
        pc_lo_d   = pc_lo_q;

        unique case (state_q)
            StIdle: begin
                if (Req) begin
                    case (req_op)
                        OpLdd: begin
                            mem_re    = 1'b1;
                            mem_addr  = EffAddr;
                            rd_data_d = MemDataOut;
                            done_d    = 1'b1;
                        end
                        OpStd: begin
                            mem_we    = 1'b1;
                            mem_addr  = EffAddr;
                            mem_wdata = WrData;
                            done_d    = 1'b1;
                        end
                        OpPush: begin
                            mem_we    = 1'b1;
                            mem_addr  = Sp;
                            mem_wdata = WrData;
                            sp_upd    = SpDec1;
                            done_d    = 1'b1;
                        end
                        OpPop: begin
                            mem_re    = 1'b1;
                            mem_addr  = Sp + ADDR_W'(1);
                            rd_data_d = MemDataOut;
                            sp_upd    = SpInc1;
                            done_d    = 1'b1;
                        end
                        OpCall: begin
                            mem_we    = 1'b1;
                            mem_addr  = Sp;
                            mem_wdata = PcIn[2*DATA_W-1:DATA_W];
                            pc_lo_d   = PcIn[DATA_W-1:0];
                            stall     = 1'b1;
                            op_d      = OpCall;
                            state_d   = StSecond;
                        end
                        OpRet: begin
                            mem_re    = 1'b1;
                            mem_addr  = Sp + ADDR_W'(1);
                            pc_lo_d   = MemDataOut;
                            stall     = 1'b1;
                            op_d      = OpRet;
                            state_d   = StSecond;
                        end
                        default: ; // NOP / reserved: accepted, no access
                    endcase
                end
            end
            StSecond: begin
                // Any Req here is ignored; Ready is low.
                done_d  = 1'b1;
                state_d = StIdle;
                if (op_q == OpCall) begin
                    mem_we    = 1'b1;
                    mem_addr  = Sp - ADDR_W'(1);
                    mem_wdata = pc_lo_q;
                    sp_upd    = SpDec2;
                end else begin
                    mem_re    = 1'b1;
                    mem_addr  = Sp + ADDR_W'(2);
                    pc_out_d  = {MemDataOut, pc_lo_q};
                    sp_upd    = SpInc2;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= StIdle;
            op_q      <= OpNop;
            done_q    <= 1'b0;
            rd_data_q <= '0;
            pc_out_q  <= '0;
            pc_lo_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
            pc_out_q  <= pc_out_d;
            pc_lo_q   <= pc_lo_d;
        end
    end

    assign Ready     = (state_q == StIdle);
    assign Stall     = stall;
    assign Done      = done_q;
    assign RdData    = rd_data_q;
    assign PcOut     = pc_out_q;
    assign MemeWrite = mem_we;
    assign MemeRead  = mem_re;
    assign MemAddr   = mem_addr;
    assign MemDataIn = mem_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Req = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [10:0] EffAddr = '0;
    logic [15:0] WrData = '0;
    logic [31:0] PcIn = '0;
    logic        Ready, Stall, Done;
    logic [15:0] RdData;
    logic [31:0] PcOut;
    logic [10:0] Sp;
    logic        MemeWrite, MemeRead;
    logic [10:0] MemAddr;
    logic [15:0] MemDataIn;
    logic [15:0] MemDataOut;

    logic [15:0] mem [2048];
    int          n_tests = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          wr_snap, done_snap;
    logic [15:0] prev_word;

    localparam logic [2:0] NOP = 3'd0, LDD = 3'd1, STD = 3'd2, PUSH = 3'd3,
                           POP = 3'd4, CALL = 3'd5, RET = 3'd6;

    mem_access_ctrl dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Req        (Req),
        .Op         (Op),
        .EffAddr    (EffAddr),
        .WrData     (WrData),
        .PcIn       (PcIn),
        .Ready      (Ready),
        .Stall      (Stall),
        .Done       (Done),
        .RdData     (RdData),
        .PcOut      (PcOut),
        .Sp         (Sp),
        .MemeWrite  (MemeWrite),
        .MemeRead   (MemeRead),
        .MemAddr    (MemAddr),
        .MemDataIn  (MemDataIn),
        .MemDataOut (MemDataOut)
    );

    always #5 Clk = ~Clk;

    // Memory model: combinational read, write at the falling edge.
    assign MemDataOut = mem[MemAddr];
    always @(negedge Clk) begin
        if (MemeWrite === 1'b1) begin
            mem[MemAddr] <= MemDataIn;
            wr_cnt++;
        end
        if (Done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [10:0] ea, input logic [15:0] wd,
                         input logic [31:0] pc);
        Req = 1'b1;
        Op = op;
        EffAddr = ea;
        WrData = wd;
        PcIn = pc;
        #1;
    endtask

    task automatic idle;
        Req = 1'b0;
        Op = NOP;
        EffAddr = '0;
        WrData = '0;
        PcIn = '0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;

        // Reset values
        tick;
        chk("rst_sp", Sp, 32'd2047);
        chk("rst_ready", Ready, 1);
        chk("rst_stall", Stall, 0);
        chk("rst_done", Done, 0);
        chk("rst_we", MemeWrite, 0);
        chk("rst_re", MemeRead, 0);
        chk("rst_addr", MemAddr, 0);
        chk("rst_rddata", RdData, 0);
        chk("rst_pcout", PcOut, 0);
        Rst = 1'b1;
        tick;

        // STD then LDD
        drive(STD, 11'h010, 16'hBEEF, 32'h0);
        chk("std_we", MemeWrite, 1);
        chk("std_addr", MemAddr, 32'h010);
        chk("std_data", MemDataIn, 32'hBEEF);
        chk("std_stall", Stall, 0);
        tick;
        idle;
        chk("std_done", Done, 1);
        chk("std_mem", mem[11'h010], 32'hBEEF);
        chk("std_sp", Sp, 32'd2047);
        drive(LDD, 11'h010, 16'h0, 32'h0);
        chk("ldd_re", MemeRead, 1);
        chk("ldd_we", MemeWrite, 0);
        chk("ldd_addr", MemAddr, 32'h010);
        tick;
        idle;
        chk("ldd_done", Done, 1);
        chk("ldd_rddata", RdData, 32'hBEEF);
        chk("ldd_sp", Sp, 32'd2047);
        tick;
        chk("ldd_done_once", Done, 0);
        chk("ldd_rddata_hold", RdData, 32'hBEEF);

        // PUSH x2, POP x2
        drive(PUSH, 11'h0, 16'h1234, 32'h0);
        chk("push1_addr", MemAddr, 32'd2047);
        chk("push1_data", MemDataIn, 32'h1234);
        tick;
        drive(PUSH, 11'h0, 16'h5678, 32'h0);
        chk("push2_done", Done, 1);
        chk("push2_addr", MemAddr, 32'd2046);
        tick;
        idle;
        chk("push2_sp", Sp, 32'd2045);
        chk("push_mem2047", mem[2047], 32'h1234);
        chk("push_mem2046", mem[2046], 32'h5678);
        drive(POP, 11'h0, 16'h0, 32'h0);
        chk("pop1_re", MemeRead, 1);
        chk("pop1_addr", MemAddr, 32'd2046);
        tick;
        idle;
        chk("pop1_rddata", RdData, 32'h5678);
        chk("pop1_sp", Sp, 32'd2046);
        drive(POP, 11'h0, 16'h0, 32'h0);
        chk("pop2_addr", MemAddr, 32'd2047);
        tick;
        idle;
        chk("pop2_rddata", RdData, 32'h1234);
        chk("pop2_sp", Sp, 32'd2047);
        chk("pop2_done", Done, 1);

        // NOP accepted without access or Done
        drive(NOP, 11'h0, 16'h0, 32'h0);
        chk("nop_we", MemeWrite, 0);
        chk("nop_re", MemeRead, 0);
        tick;
        idle;
        chk("nop_done", Done, 0);

        // CALL / RET
        done_snap = done_cnt;
        drive(CALL, 11'h0, 16'h0, 32'hCAFE0042);
        chk("call1_stall", Stall, 1);
        chk("call1_we", MemeWrite, 1);
        chk("call1_addr", MemAddr, 32'd2047);
        chk("call1_data", MemDataIn, 32'hCAFE);
        tick;
        idle;
        chk("call2_stall", Stall, 0);
        chk("call2_ready", Ready, 0);
        chk("call2_done", Done, 0);
        chk("call2_addr", MemAddr, 32'd2046);
        chk("call2_data", MemDataIn, 32'h0042);
        tick;
        chk("call_done", Done, 1);
        chk("call_sp", Sp, 32'd2045);
        chk("call_ready", Ready, 1);
        chk("call_mem_hi", mem[2047], 32'hCAFE);
        chk("call_mem_lo", mem[2046], 32'h0042);
        drive(RET, 11'h0, 16'h0, 32'h0);
        chk("ret1_stall", Stall, 1);
        chk("ret1_re", MemeRead, 1);
        chk("ret1_addr", MemAddr, 32'd2046);
        tick;
        idle;
        chk("ret2_addr", MemAddr, 32'd2047);
        chk("ret2_stall", Stall, 0);
        tick;
        chk("ret_pcout", PcOut, 32'hCAFE0042);
        chk("ret_sp", Sp, 32'd2047);
        chk("ret_done", Done, 1);
        tick;
        chk("ret_done_once", Done, 0);
        chk("callret_done_cnt", done_cnt - done_snap, 2);

        // Req held during SECOND is ignored
        wr_snap = wr_cnt;
        done_snap = done_cnt;
        drive(CALL, 11'h0, 16'h0, 32'h11112222);
        tick;
        drive(PUSH, 11'h0, 16'hDEAD, 32'h0);
        chk("bp_second_addr", MemAddr, 32'd2046);
        chk("bp_second_data", MemDataIn, 32'h2222);
        tick;
        idle;
        chk("bp_sp", Sp, 32'd2045);
        tick;
        chk("bp_writes", wr_cnt - wr_snap, 2);
        chk("bp_dones", done_cnt - done_snap, 1);
        chk("bp_mem_lo", mem[2046], 32'h2222);
        drive(RET, 11'h0, 16'h0, 32'h0);
        tick;
        idle;
        tick;
        chk("bp_ret_pcout", PcOut, 32'h11112222);
        chk("bp_ret_sp", Sp, 32'd2047);

        // Wrap-around: push down to 0, then one more wraps to 2047
        for (int i = 0; i < 2047; i++) begin
            drive(PUSH, 11'h0, 16'(i), 32'h0);
            tick;
        end
        idle;
        chk("wrap_sp0", Sp, 0);
        drive(PUSH, 11'h0, 16'hA5A5, 32'h0);
        chk("wrap_push_addr", MemAddr, 0);
        tick;
        idle;
        chk("wrap_sp", Sp, 32'd2047);
        chk("wrap_mem0", mem[0], 32'hA5A5);
        drive(POP, 11'h0, 16'h0, 32'h0);
        chk("wrap_pop_addr", MemAddr, 0);
        tick;
        idle;
        chk("wrap_pop_rddata", RdData, 32'hA5A5);
        chk("wrap_pop_sp", Sp, 0);

        // Mid-run reset
        Rst = 1'b0;
        #1;
        chk("mrst_sp", Sp, 32'd2047);
        chk("mrst_ready", Ready, 1);
        chk("mrst_rddata", RdData, 0);
        tick;
        Rst = 1'b1;
        tick;

        // Reset while in SECOND of a CALL
        prev_word = mem[2046];
        drive(CALL, 11'h0, 16'h0, 32'h77778888);
        tick;
        idle;
        wr_snap = wr_cnt;
        done_snap = done_cnt;
        chk("rsec_pending_we", MemeWrite, 1);
        Rst = 1'b0;
        #1;
        chk("rsec_we", MemeWrite, 0);
        chk("rsec_ready", Ready, 1);
        chk("rsec_sp", Sp, 32'd2047);
        tick;
        tick;
        chk("rsec_writes", wr_cnt - wr_snap, 0);
        chk("rsec_dones", done_cnt - done_snap, 0);
        chk("rsec_mem_hi", mem[2047], 32'h7777);
        chk("rsec_mem_lo", mem[2046], {16'h0, prev_word});
        Rst = 1'b1;
        tick;
        drive(PUSH, 11'h0, 16'h0BAD, 32'h0);
        tick;
        idle;
        chk("post_push_sp", Sp, 32'd2046);
        chk("post_push_mem", mem[2047], 32'h0BAD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Memory-stage initiator that drives the 16-bit, 2048-word data memory port: MemeWrite, MemeRead, Addr and DataIn out, DataOut back. It turns pipeline memory ops (load, store, push, pop, call, return) into single- or two-word memory accesses. It owns the stack pointer and stalls the pipeline for 32-bit PC push/pop.

Parameters:
- ADDR_W, 11, memory word-address width
- DATA_W, 16, memory data width
- SP_RESET, 2047, stack pointer value after reset (stack grows downward)

Ports:
- Clk  in  1  system clock; posedge logic, memory writes on negedge
- Rst  in  1  asynchronous, active-low reset
- Req  in  1  request valid from pipeline
- Op  in  3  operation code (package encoding)
- EffAddr  in  11  effective address for LDD/STD
- WrData  in  16  store/push data
- PcIn  in  32  return PC for CALL
- Ready  out  1  block idle; Req accepted only when high
- Stall  out  1  pipeline hold request
- Done  out  1  one-cycle pulse: operation finished
- RdData  out  16  LDD/POP result
- PcOut  out  32  RET target PC
- Sp  out  11  current stack pointer
- MemeWrite  out  1  memory write enable
- MemeRead  out  1  memory read enable
- MemAddr  out  11  memory address
- MemDataIn  out  16  write data to memory
- MemDataOut  in  16  combinational read data from memory

Behaviour:
- Reset (Rst=0, async): state IDLE, Sp=SP_RESET, Done=0, RdData=0, PcOut=0, captured PC=0. MemeWrite, MemeRead, MemAddr and MemDataIn read 0. Ready=1. Stall=0.
- States: IDLE and SECOND. Ready=(state==IDLE).
- Memory outputs are combinational from state plus request. With no access, all memory outputs are 0.
- Req while not Ready is ignored. Op 0 or 7 (NOP or reserved) is accepted but drives no access and produces no Done.
- Single-word ops (accepted in IDLE; access occurs in the acceptance cycle):
  - LDD: MemeRead=1, MemAddr=EffAddr. RdData<=MemDataOut at posedge.
  - STD: MemeWrite=1, MemAddr=EffAddr, MemDataIn=WrData.
  - PUSH: write WrData at Sp. Sp<=Sp-1.
  - POP: read at Sp+1. RdData<=MemDataOut. Sp<=Sp+1.
  - Done=1 in the following cycle. Stall stays 0.
- Two-word ops (Stall=1 combinationally in the acceptance cycle; go to SECOND):
  - CALL: cycle 1 writes PcIn[31:16] at Sp and captures PcIn[15:0]. Cycle 2 (SECOND) writes the captured low word at Sp-1. Sp<=Sp-2 at the end of SECOND.
  - RET: cycle 1 reads the low word at Sp+1 and captures it. Cycle 2 reads the high word at Sp+2. PcOut<={high,low}. Sp<=Sp+2 at the end of SECOND.
  - In SECOND: Stall=0, Ready=0. Done pulses in the cycle after SECOND, then back to IDLE.
- Done lasts exactly one cycle. RdData and PcOut hold until the next LDD/POP or RET.
- Sp arithmetic is modulo 2^11 (2047+1 -> 0, 0-1 -> 2047). No overflow detection.
- Writes complete at the negedge inside the access cycle. Outputs must stay stable from the posedge through that negedge.
- Reset during SECOND: aborts with no second access and no Done. Sp returns to SP_RESET. A first word already written stays in memory.

Decomposition:
- Shared package mem_ops_pkg:
  - op codes: NOP=0, LDD=1, STD=2, PUSH=3, POP=4, CALL=5, RET=6, reserved=7
  - ADDR_W and DATA_W constants
  - state encoding
- Optional sub-module stack_pointer: holds Sp and applies -1/+1/-2/+2 updates and the async reset to SP_RESET.

Test Plan:
- Reset: Rst=0 mid-run -> Sp=2047, Ready=1, Stall=0, Done=0, MemeWrite=MemeRead=0.
- Load/store: STD EffAddr=0x010, WrData=0xBEEF; then LDD 0x010 -> Done the cycle after each, RdData=0xBEEF, Sp unchanged.
- Push/pop: PUSH 0x1234, then PUSH 0x5678 -> writes at 2047 then 2046, Sp=2045. POP twice -> RdData 0x5678 then 0x1234, Sp=2047.
- Call/return: CALL PcIn=0xCAFE0042 -> Stall high for one cycle, mem[2047]=0xCAFE, mem[2046]=0x0042, Sp=2045. RET -> PcOut=0xCAFE0042, Sp=2047, one Done pulse.
- Wrap-around and backpressure: force Sp=0 via pushes, then PUSH -> write at 0, Sp=2047. A Req asserted during SECOND is ignored (no extra access, no extra Done).
- Reset during the second word: assert Rst in SECOND of a CALL -> no second write, no Done, Sp=2047, mem[2047] keeps the high word.
